// File: rtl/seq_normalizer.sv
// rtl/seq_normalizer.sv - multi-cycle binary-search normalizer (leading/trailing zero count)
// Optional feature macro: SEQ_NORM_FLUSH_EN adds a synchronous flush input.
module seq_normalizer #(
  parameter int unsigned N = 32,
  localparam int unsigned L = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [L-1:0] out_cnt,
  output logic         out_zero
`ifdef SEQ_NORM_FLUSH_EN
  ,
  input  logic         flush
`endif
);

  typedef logic [L-1:0] cnt_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam cnt_t K_TOP = cnt_t'(L - 1);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] data_q, data_d;
  cnt_t         cnt_q, cnt_d;
  cnt_t         k_q, k_d;
  logic         mode_q, mode_d;
  logic         zero_q, zero_d;

  cnt_t         stage_w;
  logic [N-1:0] hi_mask;
  logic [N-1:0] lo_mask;
  logic         take_in;

  assign stage_w = cnt_t'(1) << k_q;
  assign hi_mask = ~({N{1'b1}} >> stage_w);
  assign lo_mask = ~({N{1'b1}} << stage_w);

`ifdef SEQ_NORM_FLUSH_EN
  assign take_in = in_valid && !flush;
`else
  assign take_in = in_valid;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    mode_d  = mode_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (take_in) begin
          data_d  = in_data;
          mode_d  = in_mode;
          cnt_d   = '0;
          zero_d  = (in_data == '0);
          // A zero operand spends one idle pass in SHIFT so its result lands one edge after accept.
          k_d     = (in_data == '0) ? '0 : K_TOP;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!zero_q) begin
          if (!mode_q && ((data_q & hi_mask) == '0)) begin
            data_d = data_q << stage_w;
            cnt_d  = cnt_q + stage_w;
          end else if (mode_q && ((data_q & lo_mask) == '0)) begin
            data_d = data_q >> stage_w;
            cnt_d  = cnt_q + stage_w;
          end
        end
        if (k_q == '0) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q - cnt_t'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SEQ_NORM_FLUSH_EN
    if (flush) begin
      state_d = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = data_q;
  assign out_cnt   = cnt_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// tb/tb_seq_normalizer.sv - directed bench for seq_normalizer with a reference model and per-cycle compare
module tb_seq_normalizer;

  localparam int N = 32;
  localparam int L = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [L-1:0]  out_cnt;
  logic          out_zero;
`ifdef SEQ_NORM_FLUSH_EN
  logic          flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seq_normalizer #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_zero  (out_zero)
`ifdef SEQ_NORM_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: shift one bit at a time until the target end bit is set.
  task automatic model(input logic [31:0] d, input logic m,
                       output logic [31:0] od, output logic [4:0] oc, output logic oz);
    int n;
    od = d;
    n  = 0;
    oz = (d == 0);
    if (!oz) begin
      if (!m) begin
        while (!od[31]) begin od = od << 1; n++; end
      end else begin
        while (!od[0]) begin od = od >> 1; n++; end
      end
    end
    oc = 5'(n);
  endtask

  // Per-cycle compare against the model.
  bit          pend = 0;
  logic [31:0] p_d;
  logic [4:0]  p_c;
  logic        p_z;
  int          rdy_edge;

  always @(negedge clk) begin
    logic exp_v;
    if (!rst_n) begin
      pend = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_cnt", out_cnt, 0);
      chk("rst_out_zero", out_zero, 0);
    end else begin
      exp_v = pend && (cyc >= rdy_edge);
      chk("out_valid", out_valid, exp_v);
      chk("in_ready", in_ready, !pend);
      if (out_valid && exp_v) begin
        chk("out_data", out_data, p_d);
        chk("out_cnt", out_cnt, p_c);
        chk("out_zero", out_zero, p_z);
      end
      if (pend && exp_v && out_ready) begin
        pend = 0;
      end else if (!pend && in_valid) begin
        model(in_data, in_mode, p_d, p_c, p_z);
        pend     = 1;
        rdy_edge = cyc + 1 + (p_z ? 1 : L);
      end
    end
  end

  task automatic wait_ready(output int acc_edge);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) chk("accept_timeout", 0, 1);
    acc_edge = cyc + 1;
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [31:0] d, input logic m, input logic [31:0] ed,
                        input logic [4:0] ec, input logic ez, input int elat, input int hold);
    int t_acc;
    @(posedge clk); #1;
    in_data = d; in_mode = m; in_valid = 1; out_ready = (hold == 0);
    wait_ready(t_acc);
    @(posedge clk); #1;
    in_valid = 0;
    wait_valid();
    chk("latency", cyc - t_acc, elat);
    chk("lit_data", out_data, ed);
    chk("lit_cnt", out_cnt, ec);
    chk("lit_zero", out_zero, ez);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_data", out_data, ed);
        chk("bp_cnt", out_cnt, ec);
      end
      @(posedge clk); #1;
      out_ready = 1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, h;
    rst_n = 0; in_valid = 0; in_data = '0; in_mode = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    run_op(32'h12345678, 0, 32'h91A2B3C0, 5'd3, 0, 5, 0);
    run_op(32'h12345678, 1, 32'h02468ACF, 5'd3, 0, 5, 0);
    run_op(32'h00000001, 0, 32'h80000000, 5'd31, 0, 5, 0);
    run_op(32'h80000000, 1, 32'h00000001, 5'd31, 0, 5, 0);
    run_op(32'h00000000, 0, 32'h00000000, 5'd0, 1, 1, 0);
    run_op(32'h00000000, 1, 32'h00000000, 5'd0, 1, 1, 0);
    run_op(32'h80000000, 0, 32'h80000000, 5'd0, 0, 5, 0);
    run_op(32'h00010000, 1, 32'h00000001, 5'd16, 0, 5, 3);

    // Backpressure with a second operand waiting on in_valid.
    @(posedge clk); #1;
    in_data = 32'h00000001; in_mode = 0; in_valid = 1; out_ready = 0;
    wait_ready(acc);
    @(posedge clk); #1;
    in_data = 32'h80000000; in_mode = 1;
    wait_valid();
    chk("b2b_a_data", out_data, 32'h80000000);
    chk("b2b_a_cnt", out_cnt, 31);
    repeat (3) begin
      @(negedge clk);
      chk("b2b_in_ready", in_ready, 0);
      chk("b2b_hold_data", out_data, 32'h80000000);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    h = cyc;
    wait_ready(acc);
    chk("b2b_accept_edge", acc, h + 1);
    @(posedge clk); #1;
    in_valid = 0;
    wait_valid();
    chk("b2b_b_data", out_data, 32'h00000001);
    chk("b2b_b_cnt", out_cnt, 31);
    @(posedge clk); #1;

    // Reset mid-SHIFT discards the operand.
    in_data = 32'h0000F000; in_mode = 0; in_valid = 1;
    wait_ready(acc);
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      chk("no_stale_valid", out_valid, 0);
    end
    run_op(32'h0000F000, 0, 32'hF0000000, 5'd16, 0, 5, 0);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
